// File: rtl/fc_layer_stream_if.sv
// Stream and weight-port bundle for fc_layer_stream.
// The layer connects through the slave modport; its driver or upstream uses master.
interface fc_layer_stream_if #(
   parameter int unsigned M = 8,
   parameter int unsigned N = 4,
   parameter int unsigned T = 16
);
   localparam int unsigned AW = (M * N > 1) ? $clog2(M * N) : 1;

   logic                 input_valid;
   logic                 input_ready;
   logic signed [T-1:0]  input_data;
   logic                 output_valid;
   logic                 output_ready;
   logic signed [T-1:0]  output_data;
   logic                 w_wr_en;
   logic [AW-1:0]        w_wr_addr;
   logic signed [T-1:0]  w_wr_data;

   modport slave (
      input  input_valid, input_data, output_ready, w_wr_en, w_wr_addr, w_wr_data,
      output input_ready, output_valid, output_data
   );

   modport master (
      output input_valid, input_data, output_ready, w_wr_en, w_wr_addr, w_wr_data,
      input  input_ready, output_valid, output_data
   );
endinterface

// File: rtl/fc_layer_stream.sv
// Streaming fully-connected layer: buffers N inputs, runs M dot products on P lanes
// against a loadable weight memory, then rescales, saturates, optionally ReLUs, streams M results.
module fc_layer_stream #(
   parameter int unsigned M    = 8,
   parameter int unsigned N    = 4,
   parameter int unsigned T    = 16,
   parameter int unsigned P    = 2,
   parameter int unsigned FRAC = 0,
   parameter int unsigned RELU = 1
) (
   input logic             clk,
   input logic             reset,
   fc_layer_stream_if.slave bus
);
   localparam int unsigned AW    = (M * N > 1) ? $clog2(M * N) : 1;
   localparam int unsigned ACC_W = 2 * T + $clog2(N);
   localparam int unsigned G     = M / P;
   localparam int unsigned NW    = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW    = $clog2(N + 2);
   localparam int unsigned PW    = (P > 1) ? $clog2(P) : 1;
   localparam int unsigned GW    = (G > 1) ? $clog2(G) : 1;

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - T + 1){1'b0}}, {(T - 1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W - T + 1){1'b1}}, {(T - 1){1'b0}}};

   typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_DRAIN} state_e;

   state_e                   state_q, state_d;
   logic [NW-1:0]            in_cnt_q, in_cnt_d;
   logic [GW-1:0]            g_q, g_d;
   logic [CW-1:0]            c_q, c_d;
   logic [PW-1:0]            d_cnt_q, d_cnt_d;
   logic signed [T-1:0]      x_q [N];
   logic signed [T-1:0]      x_d [N];
   logic signed [T-1:0]      rd_q [P];
   logic signed [T-1:0]      rd_d [P];
   logic signed [ACC_W-1:0]  acc_q [P];
   logic signed [ACC_W-1:0]  acc_d [P];
   logic signed [T-1:0]      buf_q [P];
   logic signed [T-1:0]      buf_d [P];
   logic                     in_rdy_q, in_rdy_d;
   logic                     out_vld_q, out_vld_d;
   logic signed [T-1:0]      out_data_q, out_data_d;

   logic signed [T-1:0]      wmem [M*N];
   logic [AW-1:0]            raddr [P];

   function automatic logic signed [2*T-1:0] mul(input logic signed [T-1:0] a,
                                                 input logic signed [T-1:0] b);
      return (2*T)'(a) * (2*T)'(b);
   endfunction

   // Rescale, clamp to the T-bit signed range, then optional ReLU.
   function automatic logic signed [T-1:0] post(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] s;
      logic signed [T-1:0]     r;
      s = a >>> FRAC;
      if (s > SAT_MAX)      r = SAT_MAX[T-1:0];
      else if (s < SAT_MIN) r = SAT_MIN[T-1:0];
      else                  r = s[T-1:0];
      if (RELU != 0 && r[T-1]) r = '0;
      return r;
   endfunction

   assign bus.input_ready  = in_rdy_q;
   assign bus.output_valid = out_vld_q;
   assign bus.output_data  = out_data_q;

   // Weight memory: writable only while idle in LOAD, never reset.
   always_ff @(posedge clk) begin
      if (bus.w_wr_en && state_q == ST_LOAD && in_cnt_q == '0 &&
          {1'b0, bus.w_wr_addr} < (AW+1)'(M * N))
         wmem[bus.w_wr_addr] <= bus.w_wr_data;
   end

   always_comb begin
      for (int p = 0; p < P; p++)
         raddr[p] = AW'((int'(g_q) * P + p) * N + int'(c_q));
   end

   always_comb begin
      state_d    = state_q;
      in_cnt_d   = in_cnt_q;
      g_d        = g_q;
      c_d        = c_q;
      d_cnt_d    = d_cnt_q;
      x_d        = x_q;
      rd_d       = rd_q;
      acc_d      = acc_q;
      buf_d      = buf_q;
      in_rdy_d   = in_rdy_q;
      out_vld_d  = out_vld_q;
      out_data_d = out_data_q;

      case (state_q)
         ST_LOAD: begin
            in_rdy_d = 1'b1;
            if (bus.input_valid && in_rdy_q) begin
               x_d[in_cnt_q] = bus.input_data;
               if (in_cnt_q == NW'(N - 1)) begin
                  in_cnt_d = '0;
                  g_d      = '0;
                  c_d      = '0;
                  in_rdy_d = 1'b0;
                  state_d  = ST_COMPUTE;
               end else begin
                  in_cnt_d = in_cnt_q + NW'(1);
               end
            end
         end

         // c=0..N-1 reads w[n]; c=1..N accumulates the previous read; c=N+1 finalises.
         ST_COMPUTE: begin
            for (int p = 0; p < P; p++) begin
               if (c_q < CW'(N)) rd_d[p] = wmem[raddr[p]];
               if (c_q == '0)
                  acc_d[p] = '0;
               else if (c_q <= CW'(N))
                  acc_d[p] = acc_q[p] + ACC_W'(mul(x_q[NW'(c_q - CW'(1))], rd_q[p]));
            end
            if (c_q == CW'(N + 1)) begin
               for (int p = 0; p < P; p++) buf_d[p] = post(acc_q[p]);
               out_data_d = post(acc_q[0]);
               out_vld_d  = 1'b1;
               d_cnt_d    = '0;
               c_d        = '0;
               state_d    = ST_DRAIN;
            end else begin
               c_d = c_q + CW'(1);
            end
         end

         ST_DRAIN: begin
            if (out_vld_q && bus.output_ready) begin
               if (d_cnt_q == PW'(P - 1)) begin
                  out_vld_d = 1'b0;
                  if (g_q == GW'(G - 1)) begin
                     in_rdy_d = 1'b1;
                     state_d  = ST_LOAD;
                  end else begin
                     g_d     = g_q + GW'(1);
                     c_d     = '0;
                     state_d = ST_COMPUTE;
                  end
               end else begin
                  d_cnt_d    = d_cnt_q + PW'(1);
                  out_data_d = buf_q[PW'(d_cnt_q + PW'(1))];
               end
            end
         end

         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_LOAD;
         in_cnt_q   <= '0;
         g_q        <= '0;
         c_q        <= '0;
         d_cnt_q    <= '0;
         x_q        <= '{default: '0};
         rd_q       <= '{default: '0};
         acc_q      <= '{default: '0};
         buf_q      <= '{default: '0};
         in_rdy_q   <= 1'b0;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         in_cnt_q   <= in_cnt_d;
         g_q        <= g_d;
         c_q        <= c_d;
         d_cnt_q    <= d_cnt_d;
         x_q        <= x_d;
         rd_q       <= rd_d;
         acc_q      <= acc_d;
         buf_q      <= buf_d;
         in_rdy_q   <= in_rdy_d;
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
      end
   end
endmodule

// File: tb/tb_fc_layer_stream.sv
// Scoreboard bench for fc_layer_stream: three instances (ReLU/no-ReLU/shifted) share one stimulus
// stream; a plain-arithmetic dot-product model feeds per-instance expectation queues.
module tb_fc_layer_stream;
   localparam int unsigned M  = 8;
   localparam int unsigned N  = 4;
   localparam int unsigned T  = 16;
   localparam int unsigned P  = 2;
   localparam int unsigned AW = $clog2(M * N);

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fc_layer_stream_if #(.M(M), .N(N), .T(T)) if_a ();
   fc_layer_stream_if #(.M(M), .N(N), .T(T)) if_b ();
   fc_layer_stream_if #(.M(M), .N(N), .T(T)) if_c ();

   fc_layer_stream #(.M(M), .N(N), .T(T), .P(P), .FRAC(0), .RELU(1))
      dut_a (.clk(clk), .reset(rst_n), .bus(if_a.slave));
   fc_layer_stream #(.M(M), .N(N), .T(T), .P(P), .FRAC(0), .RELU(0))
      dut_b (.clk(clk), .reset(rst_n), .bus(if_b.slave));
   fc_layer_stream #(.M(M), .N(N), .T(T), .P(P), .FRAC(2), .RELU(1))
      dut_c (.clk(clk), .reset(rst_n), .bus(if_c.slave));

   always_comb begin
      if_b.input_valid  = if_a.input_valid;
      if_b.input_data   = if_a.input_data;
      if_b.output_ready = if_a.output_ready;
      if_b.w_wr_en      = if_a.w_wr_en;
      if_b.w_wr_addr    = if_a.w_wr_addr;
      if_b.w_wr_data    = if_a.w_wr_data;
      if_c.input_valid  = if_a.input_valid;
      if_c.input_data   = if_a.input_data;
      if_c.output_ready = if_a.output_ready;
      if_c.w_wr_en      = if_a.w_wr_en;
      if_c.w_wr_addr    = if_a.w_wr_addr;
      if_c.w_wr_data    = if_a.w_wr_data;
   end

   logic                ov [3];
   logic                ir [3];
   logic                ordy [3];
   logic signed [T-1:0] od [3];
   assign ov[0] = if_a.output_valid;  assign ov[1] = if_b.output_valid;  assign ov[2] = if_c.output_valid;
   assign ir[0] = if_a.input_ready;   assign ir[1] = if_b.input_ready;   assign ir[2] = if_c.input_ready;
   assign ordy[0] = if_a.output_ready; assign ordy[1] = if_b.output_ready; assign ordy[2] = if_c.output_ready;
   assign od[0] = if_a.output_data;   assign od[1] = if_b.output_data;   assign od[2] = if_c.output_data;

   int exp_q [3][$];
   int cfg_relu [3] = '{1, 0, 1};
   int cfg_frac [3] = '{0, 0, 2};
   int w_m [M*N];
   int vec [N];
   int errors = 0;
   int checks = 0;
   int rdy_mode = 0;
   bit prev_stall [3] = '{0, 0, 0};
   int prev_data [3] = '{0, 0, 0};

   function automatic void chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Reference: exact dot product, arithmetic shift, clamp, optional ReLU.
   function automatic int model(input int m, input int i);
      longint acc = 0;
      longint hi  = (longint'(1) << (T - 1)) - 1;
      longint lo  = -hi - 1;
      for (int n = 0; n < N; n++) acc += longint'(vec[n]) * longint'(w_m[m*N + n]);
      acc = acc >>> cfg_frac[i];
      if (acc > hi) acc = hi;
      if (acc < lo) acc = lo;
      if (cfg_relu[i] != 0 && acc < 0) acc = 0;
      return int'(acc);
   endfunction

   function automatic void push_expected();
      for (int m = 0; m < M; m++)
         for (int i = 0; i < 3; i++) exp_q[i].push_back(model(m, i));
   endfunction

   // Monitor: output order/values, hold-under-backpressure, and no input acceptance while busy.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            prev_stall[i] <= 1'b0;
         end else begin
            if (prev_stall[i]) begin
               chk($sformatf("hold_valid%0d", i), int'(ov[i]), 1);
               chk($sformatf("hold_data%0d", i), int'(od[i]), prev_data[i]);
            end
            if (exp_q[i].size() != 0) chk($sformatf("busy_ready%0d", i), int'(ir[i]), 0);
            if (ov[i] && ordy[i]) begin
               if (exp_q[i].size() == 0) chk($sformatf("unexpected_out%0d", i), 1, 0);
               else chk($sformatf("out%0d", i), int'(od[i]), exp_q[i].pop_front());
            end
            prev_stall[i] <= ov[i] && !ordy[i];
            prev_data[i]  <= int'(od[i]);
         end
      end
   end

   initial begin
      if_a.output_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       if_a.output_ready = 1'b1;
            1:       if_a.output_ready = 1'($urandom_range(0, 1));
            default: if_a.output_ready = 1'b0;
         endcase
      end
   end

   task automatic write_w(input int addr, input int val);
      if_a.w_wr_en   = 1'b1;
      if_a.w_wr_addr = AW'(addr);
      if_a.w_wr_data = T'(val);
      @(posedge clk); #1;
      if_a.w_wr_en = 1'b0;
      w_m[addr] = val;
   endtask

   task automatic send_vec(input bit keep, input bit lat);
      int t;
      for (int n = 0; n < N; n++) begin
         if_a.input_valid = 1'b1;
         if_a.input_data  = T'(vec[n]);
         t = 0;
         while (!if_a.input_ready && t < 500) begin @(posedge clk); #1; t++; end
         if (t >= 500) begin chk("input_ready_timeout", 0, 1); return; end
         @(posedge clk); #1;
      end
      if (!keep) if_a.input_valid = 1'b0;
      push_expected();
      if (lat)
         for (int k = 1; k <= N + 2; k++) begin
            @(posedge clk); #1;
            chk($sformatf("latency_c%0d", k), int'(if_a.output_valid), int'(k == N + 2));
         end
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0 || !if_a.input_ready)
             && t < 3000) begin
         @(posedge clk); #1; t++;
      end
      if (t >= 3000) chk("idle_timeout", 0, 1);
   endtask

   task automatic set_vec(input int a, input int b, input int c, input int d);
      vec[0] = a; vec[1] = b; vec[2] = c; vec[3] = d;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int t;
      rst_n = 1'b0;
      if_a.input_valid = 1'b0;
      if_a.input_data  = '0;
      if_a.w_wr_en     = 1'b0;
      if_a.w_wr_addr   = '0;
      if_a.w_wr_data   = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_valid%0d", i), int'(ov[i]), 0);
         chk($sformatf("rst_ready%0d", i), int'(ir[i]), 0);
         chk($sformatf("rst_data%0d", i), int'(od[i]), 0);
      end
      rst_n = 1'b1;

      // Basic: all-ones weights, 1..4 -> 10 everywhere (2 after the >>>2 instance).
      for (int a = 0; a < M*N; a++) write_w(a, 1);
      set_vec(1, 2, 3, 4);
      send_vec(0, 1);
      wait_idle();

      // Signed weights m-4 with unit inputs.
      for (int a = 0; a < M*N; a++) write_w(a, a / N - 4);
      set_vec(1, 1, 1, 1);
      send_vec(0, 1);
      wait_idle();

      // Saturation both directions and the shifted rounding case.
      for (int a = 0; a < M*N; a++) write_w(a, 32767);
      set_vec(32767, 32767, 32767, 32767);
      send_vec(0, 1);
      wait_idle();
      for (int a = 0; a < M*N; a++) write_w(a, -32768);
      send_vec(0, 0);
      wait_idle();
      for (int a = 0; a < M*N; a++) write_w(a, 1);
      set_vec(3, 3, 3, 2);
      send_vec(0, 1);
      wait_idle();

      // Backpressure mid-drain, with the next vector's valid held high throughout.
      for (int a = 0; a < M*N; a++) write_w(a, int'($urandom_range(0, 200)) - 100);
      for (int n = 0; n < N; n++) vec[n] = int'($urandom_range(0, 200)) - 100;
      send_vec(1, 1);
      @(posedge clk); #1;
      rdy_mode = 2;
      repeat (5) begin @(posedge clk); #1; end
      rdy_mode = 0;
      for (int n = 0; n < N; n++) vec[n] = int'($urandom_range(0, 200)) - 100;
      send_vec(0, 1);
      wait_idle();

      // Weight writes are dropped outside idle LOAD.
      for (int a = 0; a < M*N; a++) write_w(a, 1);
      set_vec(1, 2, 3, 4);
      send_vec(0, 0);
      if_a.w_wr_en   = 1'b1;
      if_a.w_wr_addr = '0;
      if_a.w_wr_data = 16'sd5;
      @(posedge clk); #1;
      if_a.w_wr_en = 1'b0;
      wait_idle();
      send_vec(0, 1);
      wait_idle();
      write_w(0, 5);
      send_vec(0, 1);
      wait_idle();

      // Random weights/inputs over the full range with random output backpressure.
      rdy_mode = 1;
      for (int r = 0; r < 4; r++) begin
         for (int a = 0; a < M*N; a++) write_w(a, int'($urandom_range(0, 65535)) - 32768);
         for (int n = 0; n < N; n++) vec[n] = int'($urandom_range(0, 65535)) - 32768;
         send_vec(0, 1);
         wait_idle();
      end
      rdy_mode = 0;

      // Reset two cycles into group 1; weights must survive.
      for (int a = 0; a < M*N; a++) write_w(a, 1);
      set_vec(1, 2, 3, 4);
      send_vec(0, 0);
      t = 0;
      while (exp_q[0].size() != M - P && t < 200) begin @(posedge clk); #1; t++; end
      if (t >= 200) chk("group0_timeout", 0, 1);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("abort_valid%0d", i), int'(ov[i]), 0);
         chk($sformatf("abort_ready%0d", i), int'(ir[i]), 0);
         exp_q[i].delete();
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_vec(0, 1);
      wait_idle();

      for (int i = 0; i < 3; i++) chk($sformatf("leftover%0d", i), exp_q[i].size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fc_layer_stream.md
Name: fc_layer_stream

Overview:
- Parametrised fully-connected layer. Buffers an N-element input vector, computes M dot products against a loadable weight memory using P parallel MAC lanes, and streams M results out.
- Successor to the fixed-size generated layer blocks. Adds runtime-loadable weights, configurable parallelism, fixed-point rescale, saturation and optional ReLU.
- Cascades directly into net tops through its valid/ready streams.

Parameters:
- M, 8, output vector length; must be a multiple of P.
- N, 4, input vector length.
- T, 16, data and weight width, signed two's complement.
- P, 2, parallel MAC lanes (1..M).
- FRAC, 0, arithmetic right shift applied to each accumulator before saturation.
- RELU, 1, when 1 negative results are forced to 0.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low.
- input_valid  in  1  input_data is valid.
- input_ready  out  1  layer accepts input_data.
- input_data  in  T  signed input element, n order 0..N-1.
- output_valid  out  1  output_data is valid.
- output_ready  in  1  downstream accepts output_data.
- output_data  out  T  signed result, m order 0..M-1.
- w_wr_en  in  1  weight write strobe.
- w_wr_addr  in  clog2(M*N)  weight index = m*N+n.
- w_wr_data  in  T  signed weight.

Behaviour:
- Reset: all outputs are 0, including input_ready and output_valid; state=LOAD; counters cleared. Weight memory contents are not cleared.
- A handshake occurs on a rising clk edge with valid&&ready.
- Reset asserted mid-operation aborts immediately. A partial vector is discarded; pending outputs are lost.
- State LOAD:
  - input_ready=1.
  - Each input handshake stores input_data at x[in_cnt] and increments in_cnt.
  - The handshake with in_cnt==N-1 moves to COMPUTE, sets g=0 and in_cnt=0.
- State COMPUTE:
  - input_ready=0. Lanes p=0..P-1 handle output m=g*P+p.
  - Each cycle n=0..N-1: registered weight read of w[m*N+n], then acc_p += x[n]*w.
  - Product width is 2T. Accumulator width is 2T+clog2(N), so it never wraps.
  - Accumulators clear at the start of each group.
  - After the last MAC, each lane computes r = acc>>>FRAC (arithmetic shift), saturates r to [-2^(T-1), 2^(T-1)-1], then applies ReLU if RELU=1.
  - The P results load into an output buffer; state moves to DRAIN.
- Latency: output_valid first asserts exactly N+2 cycles after the final input handshake edge, and the same after each group's COMPUTE entry.
- State DRAIN:
  - output_valid=1; output_data = buffer[d_cnt].
  - Each output handshake increments d_cnt.
  - When d_cnt==P-1 is handshaken:
    - if g<M/P-1, increment g and go to COMPUTE;
    - else go to LOAD.
  - output_valid and output_data hold stable while output_ready=0.
- No overlap between phases: a new input vector is accepted only after all M outputs have been handshaken.
- Weight port:
  - A write lands at the next edge only when state==LOAD and in_cnt==0.
  - Writes at any other time are silently dropped.
  - Out-of-range addresses (>=M*N) are ignored.
- input_valid during COMPUTE or DRAIN has no effect.
- output_ready with output_valid=0 has no effect.

Test Plan:
All cases use M=8, N=4, T=16, P=2, FRAC=0 unless noted.
1. Basic: load all weights=1, RELU=1; stream 1,2,3,4 -> eight outputs of 10, first output_valid 6 cycles after the 4th input handshake.
2. Signed/ReLU: weights w[m][n]=m-4; inputs 1,1,1,1 -> RELU=1 gives 0,0,0,0,0,4,8,12; rerun with RELU=0 -> -16,-12,-8,-4,0,4,8,12.
3. Saturation and shift:
   - all weights 32767, inputs 32767 -> all outputs 32767;
   - weights -32768, inputs 32767, RELU=0 -> all -32768;
   - FRAC=2, weights 1, inputs 3,3,3,2 -> all outputs 2.
4. Backpressure:
   - hold output_ready=0 for 5 cycles mid-DRAIN -> output_data unchanged, no output lost or duplicated, total exactly 8 outputs;
   - input_valid held high throughout -> input_ready stays 0 until the 8th output handshake.
5. Weight write gating: write w[0]=5 during COMPUTE -> ignored, next vector still uses the old weight; write again in idle LOAD -> takes effect.
6. Reset mid-COMPUTE: assert reset two cycles into group 1 -> output_valid and input_ready go 0 immediately; after release a fresh vector 1,2,3,4 yields the scenario-1 results with weights retained.
